hazard_controller: RTL

Central stall, flush and forwarding controller for the 5-stage ARM pipeline (IF, ID, EX, MEM, WB). It consumes register tags and control bits from the decode, execute and memory pipeline registers, and drives their enable and flush inputs plus the EX operand forwarding muxes. Branch-flush sequencing is a small state machine, and two saturating performance counters record stall cycles and flush events.

---
 rtl/hazard_controller_if.sv | 51 +++++
 rtl/hazard_controller.sv | 91 +++++++++
 2 files changed

// File: rtl/hazard_controller_if.sv
// hazard_controller_if: pipeline hazard bus between the ARM pipeline and hazard_controller
//   pipeline -> controller : ID sources/flags, EX tags/controls, MEM and WB writeback tags
//   controller -> pipeline : PC/IFID/IDEX enables and flushes, EX forwarding selects,
//                            busy_state and the two CNT_W-bit performance counters
interface hazard_controller_if #(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [3:0]       id_rn;
    logic [3:0]       id_rm;
    logic             id_uses_rn;
    logic             id_uses_rm;
    logic             id_reads_flags;
    logic [3:0]       ex_rd;
    logic [3:0]       ex_rn;
    logic [3:0]       ex_rm;
    logic             ex_wb_en;
    logic             ex_is_load;
    logic             ex_sets_flags;
    logic             ex_branch_taken;
    logic [3:0]       mem_rd;
    logic             mem_wb_en;
    logic [3:0]       wb_rd;
    logic             wb_wb_en;
    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             busy_state;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;

    modport master (
        output id_valid, id_rn, id_rm, id_uses_rn, id_uses_rm, id_reads_flags,
               ex_rd, ex_rn, ex_rm, ex_wb_en, ex_is_load, ex_sets_flags, ex_branch_taken,
               mem_rd, mem_wb_en, wb_rd, wb_wb_en,
        input  pc_en, ifid_en, idex_en, ifid_flush, idex_flush, fwd_a, fwd_b,
               busy_state, stall_cycles, flush_events
    );

    modport slave (
        input  id_valid, id_rn, id_rm, id_uses_rn, id_uses_rm, id_reads_flags,
               ex_rd, ex_rn, ex_rm, ex_wb_en, ex_is_load, ex_sets_flags, ex_branch_taken,
               mem_rd, mem_wb_en, wb_rd, wb_wb_en,
        output pc_en, ifid_en, idex_en, ifid_flush, idex_flush, fwd_a, fwd_b,
               busy_state, stall_cycles, flush_events
    );
endinterface

// File: rtl/hazard_controller.sv
// hazard_controller: stall, flush and EX forwarding control for the 5-stage ARM pipeline
//   clk, reset : rising-edge clock, synchronous active-high reset
//   hz (slave) : hazard bus; pipeline tags/controls in, enables/flushes/forwarding,
//                busy_state and saturating stall/flush counters out
module hazard_controller #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input logic               clk,
    input logic               reset,
    hazard_controller_if.slave hz
);
    localparam int FW = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t           state_q, state_d;
    logic [FW-1:0]    flush_left_q, flush_left_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_events_q, flush_events_d;
    logic             match_rn, match_rm, stall;

    assign match_rn = hz.id_valid && hz.id_uses_rn && hz.id_rn != 4'd15 && hz.ex_wb_en && hz.ex_rd == hz.id_rn;
    assign match_rm = hz.id_valid && hz.id_uses_rm && hz.id_rm != 4'd15 && hz.ex_wb_en && hz.ex_rd == hz.id_rm;
    assign stall    = ((match_rn || match_rm) && hz.ex_is_load) ||
                      (hz.id_valid && hz.id_reads_flags && hz.ex_sets_flags);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= RUN;
            flush_left_q   <= '0;
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            state_q        <= state_d;
            flush_left_q   <= flush_left_d;
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        flush_left_d   = flush_left_q;
        stall_cycles_d = stall_cycles_q;
        flush_events_d = flush_events_q;
        hz.pc_en       = 1'b1;
        hz.ifid_en     = 1'b1;
        hz.idex_en     = 1'b1;
        hz.ifid_flush  = 1'b0;
        hz.idex_flush  = 1'b0;
        if (reset) begin
            hz.pc_en      = 1'b0;
            hz.ifid_en    = 1'b0;
            hz.idex_en    = 1'b0;
            hz.ifid_flush = 1'b1;
            hz.idex_flush = 1'b1;
        end else if (hz.ex_branch_taken) begin
            hz.ifid_flush  = 1'b1;
            hz.idex_flush  = 1'b1;
            flush_events_d = (flush_events_q == '1) ? flush_events_q : flush_events_q + CNT_W'(1);
            if (FLUSH_CYCLES > 1) begin
                state_d      = FLUSH;
                flush_left_d = FW'(FLUSH_CYCLES - 1);
            end
        end else if (state_q == FLUSH) begin
            // ID holds a bubble here, so hazard detection is deliberately ignored
            hz.ifid_flush = 1'b1;
            flush_left_d  = flush_left_q - FW'(1);
            state_d       = (flush_left_q == FW'(1)) ? RUN : FLUSH;
        end else if (stall) begin
            // bubble into EX clears the match next cycle, so the stall self-terminates
            hz.pc_en       = 1'b0;
            hz.ifid_en     = 1'b0;
            hz.idex_flush  = 1'b1;
            stall_cycles_d = (stall_cycles_q == '1) ? stall_cycles_q : stall_cycles_q + CNT_W'(1);
        end
    end

    // MEM is the younger result, so it takes priority over WB
    assign hz.fwd_a = reset ? 2'b00 :
                      (hz.mem_wb_en && hz.mem_rd == hz.ex_rn && hz.ex_rn != 4'd15) ? 2'b01 :
                      (hz.wb_wb_en && hz.wb_rd == hz.ex_rn && hz.ex_rn != 4'd15) ? 2'b10 : 2'b00;
    assign hz.fwd_b = reset ? 2'b00 :
                      (hz.mem_wb_en && hz.mem_rd == hz.ex_rm && hz.ex_rm != 4'd15) ? 2'b01 :
                      (hz.wb_wb_en && hz.wb_rd == hz.ex_rm && hz.ex_rm != 4'd15) ? 2'b10 : 2'b00;

    assign hz.busy_state   = !reset && state_q == FLUSH;
    assign hz.stall_cycles = stall_cycles_q;
    assign hz.flush_events = flush_events_q;
endmodule
